mult_div_unit: RTL and testbench

Multiply/divide unit instantiated in the EX stage, upstream of the EX/MEM pipeline register. It executes mult/multu/div/divu with fixed multi-cycle latency, holds the architectural HI/LO registers, services mthi/mtlo writes, and drives `md_out` (HI or LO for mfhi/mflo), which EX/MEM captures as its `MDout_E` input. `busy` plus the `start` strobe feed the hazard unit, which stalls subsequent MD instructions.

---
 rtl/mult_div_unit_if.sv | 25 ++
 rtl/mult_div_unit.sv | 157 +++++++++++++++
 tb/tb_mult_div_unit.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/response bundle between the EX stage and the
// multiply/divide unit. The master (EX stage / hazard logic) drives the
// strobe, opcode, operands and HI/LO read select; the slave (the unit)
// returns busy, the architectural HI/LO registers and the mfhi/mflo value.
interface mult_div_unit_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        hilo_sel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    modport master (
        output start, op, rs, rt, hilo_sel,
        input  busy, hi, lo, md_out
    );

    modport slave (
        input  start, op, rs, rt, hilo_sel,
        output busy, hi, lo, md_out
    );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: fixed-latency multiply/divide unit holding HI/LO.
// mult/multu take MULT_CYCLES busy cycles, div/divu take DIV_CYCLES; mthi/mtlo
// write in a single cycle with no busy window. Operands are captured at start,
// the result is computed from the captured copies and written on the edge the
// cycle counter reaches zero. A divide by zero runs the full busy window but
// leaves HI/LO untouched.
// Optional feature: define MD_MADD_EN to enable madd/maddu (ops 7/8), which
// accumulate the product into {HI,LO}; otherwise ops 7/8 are no-ops.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave md
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic        busy_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] a_q, b_q;
    logic [3:0]  op_q;

    logic        is_mult_op, is_div_op;
    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, den_s, den_u;
    logic [31:0] quo_mag, rem_mag, quo_s, rem_s, quo_u, rem_u;
    logic [63:0] hilo_d;
    logic        hilo_we;

    // Classify the incoming opcode into the two multi-cycle latency groups.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        is_mult_op = (md.op == OP_MULT) || (md.op == OP_MULTU);
`ifdef MD_MADD_EN
        is_mult_op = is_mult_op || (md.op == OP_MADD) || (md.op == OP_MADDU);
`endif
        is_div_op  = (md.op == OP_DIV) || (md.op == OP_DIVU);
    end

    // Arithmetic on the captured operands: 64-bit products and sign-magnitude division.
    always_comb begin
        prod_s  = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u  = {32'd0, a_q} * {32'd0, b_q};

        // Signed divide via magnitudes: quotient truncates toward zero and the
        // remainder takes the dividend's sign. 0x80000000 / -1 falls out as
        // quotient 0x80000000, remainder 0 with no special case.
        a_neg   = a_q[31];
        b_neg   = b_q[31];
        a_mag   = a_neg ? (~a_q + 32'd1) : a_q;
        b_mag   = b_neg ? (~b_q + 32'd1) : b_q;
        // A zero divisor is replaced so the dividers never see it; the
        // writeback is suppressed for that case below.
        den_s   = (b_mag == 32'd0) ? 32'd1 : b_mag;
        den_u   = (b_q == 32'd0) ? 32'd1 : b_q;
        quo_mag = a_mag / den_s;
        rem_mag = a_mag % den_s;
        quo_s   = (a_neg ^ b_neg) ? (~quo_mag + 32'd1) : quo_mag;
        rem_s   = a_neg ? (~rem_mag + 32'd1) : rem_mag;
        quo_u   = a_q / den_u;
        rem_u   = a_q % den_u;
    end

    // Select the {HI,LO} value written back when the in-flight operation completes.
    always_comb begin
        hilo_d  = {hi_q, lo_q};
        hilo_we = 1'b1;
        case (op_q)
            OP_MULT:  hilo_d = prod_s;
            OP_MULTU: hilo_d = prod_u;
            OP_DIV: begin
                if (b_q == 32'd0) hilo_we = 1'b0;
                else              hilo_d  = {rem_s, quo_s};
            end
            OP_DIVU: begin
                if (b_q == 32'd0) hilo_we = 1'b0;
                else              hilo_d  = {rem_u, quo_u};
            end
`ifdef MD_MADD_EN
            // Accumulate base is the live {HI,LO} at the completion edge.
            OP_MADD:  hilo_d = {hi_q, lo_q} + prod_s;
            OP_MADDU: hilo_d = {hi_q, lo_q} + prod_u;
`endif
            default:  hilo_we = 1'b0;
        endcase
    end

    // IDLE/RUN sequencer with registered busy, operand capture and HI/LO writeback.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (md.start) begin
                        if (is_mult_op || is_div_op) begin
                            a_q     <= md.rs;
                            b_q     <= md.rt;
                            op_q    <= md.op;
                            cnt_q   <= is_mult_op ? 5'(MULT_CYCLES) : 5'(DIV_CYCLES);
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end else if (md.op == OP_MTHI) begin
                            hi_q <= md.rs;
                        end else if (md.op == OP_MTLO) begin
                            lo_q <= md.rs;
                        end
                    end
                end
                RUN: begin
                    // start is ignored here; the captured operation runs to completion.
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (hilo_we) begin
                            hi_q <= hilo_d[63:32];
                            lo_q <= hilo_d[31:0];
                        end
                    end
                end
            endcase
        end
    end

    assign md.busy   = busy_q;
    assign md.hi     = hi_q;
    assign md.lo     = lo_q;
    assign md.md_out = md.hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: self-checking bench for mult_div_unit. Directed cases from
// the block's behaviour list plus randomized operations, all compared against
// an arithmetic reference model of HI/LO and the expected busy length.
// Build with MD_MADD_EN defined to exercise madd/maddu.
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mult_div_unit_if md_if();

    mult_div_unit #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .md   (md_if)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    // Count one comparison and report it if the observed value is wrong.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Expected number of busy cycles for an opcode.
    function automatic int exp_latency(input logic [3:0] op);
        case (op)
            4'd1, 4'd2: return MC;
            4'd3, 4'd4: return DC;
`ifdef MD_MADD_EN
            4'd7, 4'd8: return MC;
`endif
            default:    return 0;
        endcase
    endfunction

    // Reference model: architectural effect of one operation on HI/LO.
    task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = 64'(a) * 64'(b);
        case (op)
            4'd1: {m_hi, m_lo} = sp;
            4'd2: {m_hi, m_lo} = up;
            4'd3: begin
                if (b != 32'd0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        m_lo = 32'h8000_0000;
                        m_hi = 32'd0;
                    end else begin
                        sa   = a;
                        sb   = b;
                        m_lo = sa / sb;
                        m_hi = sa % sb;
                    end
                end
            end
            4'd4: begin
                if (b != 32'd0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
`ifdef MD_MADD_EN
            4'd7: {m_hi, m_lo} = {m_hi, m_lo} + sp;
            4'd8: {m_hi, m_lo} = {m_hi, m_lo} + up;
`endif
            default: ;
        endcase
    endtask

    // Issue one op, measure the busy window, then check HI/LO and both md_out reads
    // in the cycle busy falls.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        int cyc;
        md_if.start = 1'b1;
        md_if.op    = op;
        md_if.rs    = a;
        md_if.rt    = b;
        @(negedge clk);
        md_if.start = 1'b0;
        md_if.rs    = $urandom;
        md_if.rt    = $urandom;
        cyc = 0;
        while (md_if.busy && cyc < 64) begin
            cyc++;
            @(negedge clk);
        end
        model_apply(op, a, b);
        check({tag, " busy_len"}, 64'(cyc), 64'(exp_latency(op)));
        check({tag, " hilo"}, {md_if.hi, md_if.lo}, {m_hi, m_lo});
        md_if.hilo_sel = 1'b1;
        #1 check({tag, " mfhi"}, 64'(md_if.md_out), 64'(m_hi));
        md_if.hilo_sel = 1'b0;
        #1 check({tag, " mflo"}, 64'(md_if.md_out), 64'(m_lo));
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [5];
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 100)) - 32'd50;
        return $urandom;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        reset          = 1'b1;
        md_if.start    = 1'b0;
        md_if.op       = 4'd0;
        md_if.rs       = 32'd0;
        md_if.rt       = 32'd0;
        md_if.hilo_sel = 1'b0;
        m_hi           = 32'd0;
        m_lo           = 32'd0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(md_if.busy), 64'd0);
        check("reset hilo", {md_if.hi, md_if.lo}, 64'd0);
        check("reset md_out", 64'(md_if.md_out), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed arithmetic cases.
        run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3);
        check("mult const", {md_if.hi, md_if.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3);
        check("multu const", {md_if.hi, md_if.lo}, 64'h0000_0002_FFFF_FFFA);
        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2);
        check("div const", {md_if.hi, md_if.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu0", 4'd4, 32'd7, 32'd0);
        check("divu0 const", {md_if.hi, md_if.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div0", 4'd3, 32'd9, 32'd0);
        run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("divovf const", {md_if.hi, md_if.lo}, 64'h0000_0000_8000_0000);
        run_op("divrem", 4'd3, 32'd7, 32'hFFFF_FFFE);
        run_op("mthi", 4'd5, 32'h1234_5678, 32'd0);
        run_op("mtlo", 4'd6, 32'h9ABC_DEF0, 32'd0);
        check("mthi/mtlo const", {md_if.hi, md_if.lo}, 64'h1234_5678_9ABC_DEF0);

        // Disturbance mid-RUN: new operands and a div strobe must be ignored.
        md_if.start = 1'b1;
        md_if.op    = 4'd1;
        md_if.rs    = 32'd1000;
        md_if.rt    = 32'hFFFF_FFF0;
        @(negedge clk);
        md_if.start = 1'b0;
        cyc = 0;
        while (md_if.busy && cyc < 64) begin
            cyc++;
            if (cyc == 2) begin
                md_if.start = 1'b1;
                md_if.op    = 4'd3;
                md_if.rs    = 32'd77;
                md_if.rt    = 32'd5;
            end else begin
                md_if.start = 1'b0;
            end
            @(negedge clk);
        end
        md_if.start = 1'b0;
        model_apply(4'd1, 32'd1000, 32'hFFFF_FFF0);
        check("ignore busy_len", 64'(cyc), 64'(MC));
        check("ignore hilo", {md_if.hi, md_if.lo}, {m_hi, m_lo});
        repeat (DC + 2) @(negedge clk);
        check("ignore no late busy", 64'(md_if.busy), 64'd0);
        check("ignore hilo stable", {md_if.hi, md_if.lo}, {m_hi, m_lo});

        // Reset on busy cycle 4 of a divide.
        md_if.start = 1'b1;
        md_if.op    = 4'd3;
        md_if.rs    = 32'd100;
        md_if.rt    = 32'd7;
        @(negedge clk);
        md_if.start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort busy before", 64'(md_if.busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort busy", 64'(md_if.busy), 64'd0);
        check("abort hilo", {md_if.hi, md_if.lo}, 64'd0);
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        repeat (DC + 2) @(negedge clk);
        check("abort no writeback", {md_if.hi, md_if.lo}, 64'd0);
        run_op("after abort", 4'd1, 32'd123, 32'd456);

        // madd/maddu behaviour depends on the build.
        run_op("pre madd hi", 4'd5, 32'h0000_0000, 32'd0);
        run_op("pre madd lo", 4'd6, 32'hFFFF_FFFF, 32'd0);
        run_op("madd", 4'd7, 32'd1, 32'd1);
`ifdef MD_MADD_EN
        check("madd const", {md_if.hi, md_if.lo}, 64'h0000_0001_0000_0000);
        run_op("maddu", 4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("madd neg", 4'd7, 32'hFFFF_FFFF, 32'd5);
`else
        check("madd noop const", {md_if.hi, md_if.lo}, 64'h0000_0000_FFFF_FFFF);
        run_op("maddu noop", 4'd8, 32'd3, 32'd4);
`endif

        // Randomized operations, issued back to back.
        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = pick_operand();
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : pick_operand();
            run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
